// File: rtl/sobel_window.sv
// sobel_window: streams FIFO pixels into line buffers and emits 3x3 windows with valid/ready handshake
module sobel_window #(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_rdata,
    output logic        fifo_r_enable,
    input  logic        win_ready,
    output logic        win_valid,
    output logic [71:0] win_data,
    output logic        frame_done
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [7:0]    r_line0 [IMG_WIDTH];
    logic [7:0]    r_line1 [IMG_WIDTH];
    logic [23:0]   r_c0, r_c1, r_c2;
    logic          r_valid, r_done;
    logic          w_acc, w_last_col, w_last_row, w_win;

    assign w_acc         = n_rst & ~fifo_empty & (~r_valid | win_ready);
    assign w_last_col    = r_col == CW'(IMG_WIDTH - 1);
    assign w_last_row    = r_row == RW'(IMG_HEIGHT - 1);
    assign w_win         = (r_row >= RW'(2)) && (r_col >= CW'(2));
    assign fifo_r_enable = w_acc;
    assign win_valid     = r_valid;
    assign frame_done    = r_done;
    // each column register packs rows {2,1,0} high to low
    assign win_data = {r_c2[23:16], r_c1[23:16], r_c0[23:16],
                       r_c2[15:8],  r_c1[15:8],  r_c0[15:8],
                       r_c2[7:0],   r_c1[7:0],   r_c0[7:0]};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_col   <= '0;
            r_row   <= '0;
            r_c0    <= '0;
            r_c1    <= '0;
            r_c2    <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (w_acc) begin
                r_col <= w_last_col ? '0 : r_col + 1'b1;
                if (w_last_col)
                    r_row <= w_last_row ? '0 : r_row + 1'b1;
                r_c0 <= r_c1;
                r_c1 <= r_c2;
                r_c2 <= {fifo_rdata, r_line1[r_col], r_line0[r_col]};
            end
            r_valid <= w_acc ? w_win : r_valid & ~win_ready;
            r_done  <= w_acc & w_last_col & w_last_row;
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_line0[r_col] <= r_line1[r_col];
            r_line1[r_col] <= fifo_rdata;
        end
    end
endmodule
